// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready handshake, sideband tag and flush.
// Define PIPE_SHIFTER_ROTATE_EN to implement ROL/ROR; otherwise they pass data through.
module pipe_shifter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [2:0]               op,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic [TAG_W-1:0]         tag_out,
    output logic                     out_zero
);

    localparam int unsigned LOG_W = $clog2(WIDTH);
    localparam int unsigned BASE  = LOG_W / STAGES;
    localparam int unsigned REM   = LOG_W % STAGES;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
`ifdef PIPE_SHIFTER_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
`endif

    // One binary layer: shift by a fixed power-of-two amount according to op.
    function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] d,
                                               input logic [2:0]       o,
                                               input int unsigned      amt);
        logic [WIDTH-1:0] r;
        r = d;
        case (o)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = $unsigned($signed(d) >>> amt);
`ifdef PIPE_SHIFTER_ROTATE_EN
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0]             vld;
    logic [STAGES-1:0]             adv;
    logic                          acc;
    logic [STAGES:0][WIDTH-1:0]    s_dat;
    logic [STAGES:0][TAG_W-1:0]    s_tag;
    logic [STAGES-1:0][LOG_W-1:0]  s_sh;
    logic [STAGES-1:0][2:0]        s_op;

    assign s_dat[0] = din;
    assign s_tag[0] = tag_in;
    assign s_sh[0]  = shamt;
    assign s_op[0]  = op;

    // A stage advances when empty or when everything downstream of it moves.
    always_comb begin : p_adv
        logic down;
        adv  = '0;
        down = out_ready;
        for (int g = STAGES - 1; g >= 0; g--) begin
            adv[g] = ~vld[g] | down;
            down   = adv[g];
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign acc       = in_valid & in_ready;
    assign out_valid = vld[STAGES-1];
    assign dout      = s_dat[STAGES];
    assign tag_out   = s_tag[STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int unsigned GI   = g;
        localparam int unsigned LO   = GI * BASE + ((GI < REM) ? GI : REM);
        localparam int unsigned N    = BASE + ((GI < REM) ? 1 : 0);
        localparam logic [LOG_W-1:0] MASK = LOG_W'(((32'd1 << N) - 32'd1) << LO);

        logic             up_vld;
        logic [LOG_W-1:0] sh_eff;
        logic [WIDTH-1:0] res;
        logic             vld_q;
        logic [WIDTH-1:0] dat_q;
        logic [TAG_W-1:0] tag_q;

        if (g == 0) begin : g_src_in
            assign up_vld = acc;
        end else begin : g_src_stage
            assign up_vld = vld[g-1];
        end

        // Only this group's layers act; the remaining shamt bits ride along.
        assign sh_eff = s_sh[g] & MASK;

        always_comb begin
            res = s_dat[g];
            for (int unsigned k = 0; k < LOG_W; k++) begin
                if (sh_eff[k]) res = layer(res, s_op[g], 32'd1 << k);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
                tag_q <= '0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else if (adv[g]) begin
                vld_q <= up_vld;
                if (up_vld) begin
                    dat_q <= res;
                    tag_q <= s_tag[g];
                end
            end
        end

        assign vld[g]     = vld_q;
        assign s_dat[g+1] = dat_q;
        assign s_tag[g+1] = tag_q;

        if (g < STAGES - 1) begin : g_fwd
            logic [LOG_W-1:0] sh_q;
            logic [2:0]       op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_q <= '0;
                    op_q <= '0;
                end else if (!flush && adv[g] && up_vld) begin
                    sh_q <= s_sh[g];
                    op_q <= s_op[g];
                end
            end

            assign s_sh[g+1] = sh_q;
            assign s_op[g+1] = op_q;
        end else begin : g_last
            logic z_q;

            // Zero flag tracks the output register so it is only high with out_valid.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    z_q <= 1'b0;
                end else if (adv[g]) begin
                    z_q <= up_vld & (res == '0);
                end
            end

            assign out_zero = z_q;
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=32, STAGES=2, TAG_W=4).
module tb_pipe_shifter;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 2;
    localparam int unsigned TAG_W  = 4;
    localparam int          NV     = 16;

`ifdef PIPE_SHIFTER_ROTATE_EN
    localparam logic [31:0] R_ROR1 = 32'h78123456;
    localparam logic [31:0] R_ROL1 = 32'h00000003;
    localparam logic [31:0] R_ROR2 = 32'hF000000F;
`else
    localparam logic [31:0] R_ROR1 = 32'h12345678;
    localparam logic [31:0] R_ROL1 = 32'h80000001;
    localparam logic [31:0] R_ROR2 = 32'h000000FF;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [WIDTH-1:0] din, dout;
    logic [4:0]       shamt;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag_in, tag_out;

    pipe_shifter #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .shamt(shamt), .op(op), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .tag_out(tag_out), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        z;
        int          c;
    } exp_t;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] d;
        logic [4:0]  s;
        logic [3:0]  t;
        logic [31:0] e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops expectations on each output transfer and checks hold stability.
    exp_t        e_mon;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_t;
    logic        prev_z;

    always @(negedge clk) begin
        if (rst || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid)
                chk("hold_stable", {dout, tag_out, out_zero}, {prev_d, prev_t, prev_z});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got tag %0d dout 0x%0h, want no output", tag_out, dout);
                end else begin
                    e_mon = sbq.pop_front();
                    chk("dout", dout, e_mon.d);
                    chk("tag_out", tag_out, e_mon.t);
                    chk("out_zero", out_zero, e_mon.z);
                    if (e_mon.c >= 0) chk("latency", cyc, e_mon.c);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = dout;
            prev_t     = tag_out;
            prev_z     = out_zero;
        end
    end

    task automatic push_exp(input logic [31:0] e, input logic [3:0] t, input int c);
        exp_t x;
        x.d = e;
        x.t = t;
        x.z = (e == 32'h0);
        x.c = c;
        sbq.push_back(x);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [3:0] t, input logic [31:0] e, input bit lat, output int at);
        int w;
        in_valid = 1'b1;
        op       = o;
        din      = d;
        shamt    = s;
        tag_in   = t;
        w        = 0;
        at       = -1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, want 1", w);
        end else begin
            at = cyc;
            push_exp(e, t, lat ? cyc + int'(STAGES) : -1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d results outstanding, want 0", sbq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, first_acc, last_acc, acc_n, next_tag, w;
        logic [31:0] bp_exp [4];

        vecs[0]  = '{3'b010, 32'h80000000, 5'd4,  4'd5,  32'hF8000000};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 5'd31, 4'd1,  32'h00000001};
        vecs[2]  = '{3'b000, 32'h00000001, 5'd31, 4'd2,  32'h80000000};
        vecs[3]  = '{3'b000, 32'h00000000, 5'd0,  4'd3,  32'h00000000};
        vecs[4]  = '{3'b100, 32'h12345678, 5'd8,  4'd4,  R_ROR1};
        vecs[5]  = '{3'b111, 32'h12345678, 5'd5,  4'd15, 32'h12345678};
        vecs[6]  = '{3'b011, 32'h80000001, 5'd1,  4'd6,  R_ROL1};
        vecs[7]  = '{3'b010, 32'h7FFFFFF0, 5'd4,  4'd7,  32'h07FFFFFF};
        vecs[8]  = '{3'b000, 32'hA5A5A5A5, 5'd0,  4'd8,  32'hA5A5A5A5};
        vecs[9]  = '{3'b001, 32'h80000000, 5'd31, 4'd9,  32'h00000001};
        vecs[10] = '{3'b010, 32'h80000000, 5'd31, 4'd10, 32'hFFFFFFFF};
        vecs[11] = '{3'b000, 32'h0000FFFF, 5'd16, 4'd11, 32'hFFFF0000};
        vecs[12] = '{3'b101, 32'hDEADBEEF, 5'd3,  4'd12, 32'hDEADBEEF};
        vecs[13] = '{3'b100, 32'h000000FF, 5'd4,  4'd13, R_ROR2};
        vecs[14] = '{3'b000, 32'h80000000, 5'd1,  4'd14, 32'h00000000};
        vecs[15] = '{3'b001, 32'h0F0F0F0F, 5'd3,  4'd0,  32'h01E1E1E1};
        bp_exp[0] = 32'h2;
        bp_exp[1] = 32'h8;
        bp_exp[2] = 32'h18;
        bp_exp[3] = 32'h40;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        din = '0; shamt = '0; op = '0; tag_in = '0;
        first_acc = 0; last_acc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dout", dout, 0);
        chk("rst_tag_out", tag_out, 0);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors at full throughput.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].o, vecs[i].d, vecs[i].s, vecs[i].t, vecs[i].e, i == 0, a);
            if (i == 0) first_acc = a;
            last_acc = a;
        end
        chk("throughput", last_acc - first_acc, NV - 1);
        drain();

        // Backpressure: four offers against a stalled output.
        out_ready = 1'b0;
        acc_n     = 0;
        next_tag  = 1;
        in_valid  = 1'b1; op = 3'b000; din = 32'd1; shamt = 5'd1; tag_in = 4'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) chk("stall_in_ready", in_ready, 0);
            if (in_ready) begin
                push_exp(bp_exp[next_tag-1], 4'(next_tag), -1);
                acc_n++;
                next_tag++;
            end
            @(posedge clk);
            #1;
            din = 32'(next_tag); shamt = 5'(next_tag); tag_in = 4'(next_tag);
        end
        chk("stall_accepted", acc_n, 2);
        out_ready = 1'b1;
        w = 0;
        while (next_tag <= 4 && w < 50) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(bp_exp[next_tag-1], 4'(next_tag), -1);
                next_tag++;
            end
            @(posedge clk);
            #1;
            din = 32'(next_tag); shamt = 5'(next_tag); tag_in = 4'(next_tag);
            w++;
        end
        in_valid = 1'b0;
        chk("release_accepted", next_tag, 5);
        drain();

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send(3'b000, 32'h11, 5'd1, 4'd6, 32'h22, 1'b0, a);
        send(3'b001, 32'h100, 5'd4, 4'd7, 32'h10, 1'b0, a);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_dout", dout, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Flush with two in flight and a simultaneous offer.
        out_ready = 1'b0;
        send(3'b000, 32'h3, 5'd3, 4'd8, 32'h18, 1'b0, a);
        send(3'b000, 32'h4, 5'd3, 4'd9, 32'h20, 1'b0, a);
        flush = 1'b1;
        in_valid = 1'b1; op = 3'b000; din = 32'h5; shamt = 5'd1; tag_in = 4'd10;
        sbq.delete();
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(3'b000, 32'h3, 5'd2, 4'd11, 32'hC, 1'b1, a);
        drain();
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline register count; 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4, width of sideband tag carried with each operation.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous discard of all in-flight operations.
REQ-007 SHALL have port in_valid  input  1  operation offered.
REQ-008 SHALL have port in_ready  output  1  operation accepted when in_valid & in_ready.
REQ-009 SHALL have port din  input  WIDTH  operand.
REQ-010 SHALL have port shamt  input  log2(WIDTH)  shift amount, unsigned.
REQ-011 SHALL have port op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved.
REQ-012 SHALL have port tag_in  input  TAG_W  sideband tag.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-015 SHALL have port dout  output  WIDTH  result.
REQ-016 SHALL have port tag_out  output  TAG_W  tag of the result.
REQ-017 SHALL have port out_zero  output  1  high when dout == 0 and out_valid.

Function
REQ-018 SHALL compute with log2(WIDTH) binary layers (1,2,4,... positions); layers split over STAGES groups, earlier groups take the remainder, one register after each group.
REQ-019 SLL SHALL fill with 0; SRL SHALL fill with 0; SRA SHALL fill with din[WIDTH-1]; ROL/ROR SHALL wrap bits end-around.
REQ-020 Reserved op SHALL pass din unchanged, ignoring shamt.
REQ-021 shamt 0 SHALL yield dout == din for every op.
REQ-022 Operation accepted at edge t SHALL present out_valid=1 from edge t+STAGES onward until consumed (STAGES=1: visible in cycle after acceptance).
REQ-023 Each stage SHALL advance when it is empty or its downstream stage advances/consumes in the same cycle; last stage advances on out_ready.
REQ-024 in_ready SHALL be combinational: high when stage 1 is empty or stage 1 advances this cycle; full throughput 1 op/cycle with out_ready held high.
REQ-025 With out_ready low, pipeline SHALL hold STAGES operations, then drop in_ready; no operation lost, duplicated, or reordered.
REQ-026 dout, tag_out, out_zero SHALL stay stable while out_valid & !out_ready.
REQ-027 flush SHALL clear all stage valid bits at the edge; an offer in the same cycle SHALL NOT be accepted (in_ready low while flush high).
REQ-028 Data registers SHALL load only on stage advance; valid bits alone determine occupancy.

Reset
REQ-029 rst SHALL clear all stage valid bits; out_valid=0, out_zero=0, in_ready=1 the cycle after reset deasserts.
REQ-030 dout and tag_out SHALL reset to 0.
REQ-031 rst mid-operation SHALL discard all in-flight results; rst has priority over flush and acceptance.

Configuration
REQ-032 Macro PIPE_SHIFTER_ROTATE_EN defined: ROL/ROR implemented per REQ-019.
REQ-033 Macro undefined: ROL/ROR SHALL be treated as reserved (REQ-020) and no rotate wrap logic synthesised.

Verification
REQ-034 WIDTH=32, STAGES=2, out_ready=1: SRA din=0x80000000 shamt=4 accepted edge t -> out_valid at edge t+2, dout=0xF8000000, tag preserved.
REQ-035 SRL din=0xFFFFFFFF shamt=31 -> 0x00000001; SLL din=0x00000001 shamt=31 -> 0x80000000; SLL shamt=0 din=0x0 -> dout=0, out_zero=1.
REQ-036 ROR din=0x12345678 shamt=8 -> 0x78123456 with macro; 0x12345678 without; op=111 -> 0x12345678.
REQ-037 out_ready=0 for 6 cycles, 4 back-to-back offers tags 1..4 -> 2 accepted, in_ready low thereafter; release -> tags 1,2,3,4 in order, none lost.
REQ-038 rst asserted one cycle with 2 ops in flight -> out_valid=0, dout=0 next cycle, none emerge later; same scenario with flush -> out_valid=0, next accepted op emerges normally.
